// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage owning the architectural fetch PC.
// Builds each 32-bit instruction from four little-endian byte reads on the
// shared byte-wide memory port and hands {inst, pc, prediction} to IF/ID
// through a one-entry output register with a valid/stall handshake.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   fetch_pc         current fetch PC to the branch predictor (combinational)
//   pred_pc          predictor next PC for fetch_pc
//   pred_taken       predictor taken flag for fetch_pc
//   mem_req          byte read request (combinational)
//   mem_addr         byte address of the request (combinational)
//   mem_gnt          arbiter grant, same cycle as mem_req
//   mem_din          read byte, valid the cycle after a granted request
//   stall            IF/ID cannot accept this cycle
//   flush, flush_pc  redirect from EX and its target
//   inst_valid       output register holds an instruction
//   inst             instruction word
//   inst_pc          PC of inst
//   inst_pred        pred_taken sampled for inst
module if_fetch_unit #(
   parameter int unsigned          ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] fetch_pc,
   input  logic [ADDR_W-1:0] pred_pc,
   input  logic              pred_taken,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic [7:0]        mem_din,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   output logic              inst_valid,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_pred
);

   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(4);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(3);

   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0]  req_cnt;
   logic [CNT_W-1:0]  rsp_cnt;
   logic              pending;
   logic [31:0]       word_buf;

   logic              word_ready;
   logic              out_free;
   logic              xfer;
   logic              granted;
   logic [31:0]       word;

   // Request side, predictor interface and transfer decision
   always_comb begin
      fetch_pc   = pc;
      mem_req    = (req_cnt < CNT_FULL) && !flush && !rst;
      mem_addr   = pc + ADDR_W'(req_cnt);
      granted    = mem_req && mem_gnt;
      word_ready = (rsp_cnt == CNT_FULL) || (pending && (rsp_cnt == CNT_LAST));
      out_free   = !inst_valid || !stall;
      xfer       = word_ready && out_free && !flush;
      // Byte 3 is bypassed straight from the memory port when it arrives
      // in the transfer cycle itself.
      word       = (rsp_cnt == CNT_FULL) ? word_buf : {mem_din, word_buf[23:0]};
   end

   // Fetch state and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         req_cnt    <= '0;
         rsp_cnt    <= '0;
         pending    <= 1'b0;
         word_buf   <= '0;
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
         inst_pred  <= 1'b0;
      end else if (flush) begin
         // Clearing pending drops any byte still in flight.
         pc         <= flush_pc;
         req_cnt    <= '0;
         rsp_cnt    <= '0;
         pending    <= 1'b0;
         inst_valid <= 1'b0;
      end else begin
         pending <= granted;
         if (xfer) begin
            inst       <= word;
            inst_pc    <= pc;
            inst_pred  <= pred_taken;
            inst_valid <= 1'b1;
            pc         <= pred_pc;
            req_cnt    <= '0;
            rsp_cnt    <= '0;
         end else begin
            if (granted) begin
               req_cnt <= req_cnt + CNT_W'(1);
            end
            if (pending) begin
               word_buf[8*rsp_cnt[1:0] +: 8] <= mem_din;
               rsp_cnt <= rsp_cnt + CNT_W'(1);
            end
            if (inst_valid && !stall) begin
               inst_valid <= 1'b0;
            end
         end
      end
   end

endmodule
